// File: rtl/envelope_adsr.sv
// -----------------------------------------------------------------------------
// envelope_adsr
//
// Gate-driven attack/decay/sustain/release amplitude envelope applied to the
// signed mixed oscillator sample. The envelope level steps once per audio
// sample strobe. Each strobe also scales the incoming sample by the current
// level. The scaled sample appears two clocks after the strobe, together with
// a one-clock valid pulse.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst_n        synchronous reset, active low, sampled on rising clk
//   sample_tick  one-clk pulse per audio sample
//   gate         note held when high (already debounced upstream)
//   sustain      sustain level byte; the 16-bit target is {sustain, sustain}
//   sig_in       signed 16-bit mixed sample
//   sig_out      signed 16-bit enveloped sample, held between updates
//   out_valid    one-clk pulse when sig_out has just been updated
//   env_level    current unsigned envelope level (0..65535)
//   env_state    IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active       high whenever env_state is not IDLE
// -----------------------------------------------------------------------------
module envelope_adsr #(
    parameter logic [15:0] ATTACK_STEP  = 16'd64,
    parameter logic [15:0] DECAY_STEP   = 16'd16,
    parameter logic [15:0] RELEASE_STEP = 16'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        gate,
    input  logic [7:0]  sustain,
    input  logic [15:0] sig_in,
    output logic [15:0] sig_out,
    output logic        out_valid,
    output logic [15:0] env_level,
    output logic [2:0]  env_state,
    output logic        active
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Envelope state
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [15:0] level_reg;
    logic        gate_q_reg;
    logic        trig_pending_reg;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic               tick_q_reg;
    logic signed [32:0] prod_reg;
    logic signed [32:0] prod_next;
    logic [15:0]        sig_out_reg;
    logic               out_valid_reg;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        gate_rise;
    logic        trigger;
    logic [15:0] target;
    logic [16:0] attack_sum;
    logic [16:0] decay_limit;

    assign gate_rise = gate & ~gate_q_reg;

    // An edge seen on the same clock as a strobe is consumed directly by
    // that strobe, so it never has to pass through trig_pending.
    assign trigger = trig_pending_reg | gate_rise;

    assign target = {sustain, sustain};

    // Both comparisons use 17 bits. The attack sum therefore cannot wrap
    // past 65535, and target + DECAY_STEP cannot wrap near full scale. A
    // wrap would let the level undershoot the sustain target.
    assign attack_sum  = {1'b0, level_reg} + {1'b0, ATTACK_STEP};
    assign decay_limit = {1'b0, target} + {1'b0, DECAY_STEP};

    // ------------------------------------------------------------------
    // Envelope FSM: gate edge capture runs every clock. State and level
    // move only on sample strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            level_reg        <= 16'd0;
            gate_q_reg       <= 1'b0;
            trig_pending_reg <= 1'b0;
        end else begin
            gate_q_reg <= gate;

            if (sample_tick) begin
                trig_pending_reg <= 1'b0;

                if (trigger) begin
                    // Retrigger keeps the current level, so a re-pressed
                    // note ramps up from where it was without a click.
                    state_reg <= ST_ATTACK;
                end else begin
                    case (state_reg)
                        ST_ATTACK: begin
                            if (!gate) begin
                                state_reg <= ST_RELEASE;
                            end else if (attack_sum >= 17'd65535) begin
                                level_reg <= 16'hFFFF;
                                state_reg <= ST_DECAY;
                            end else begin
                                level_reg <= attack_sum[15:0];
                            end
                        end

                        ST_DECAY: begin
                            if (!gate) begin
                                state_reg <= ST_RELEASE;
                            end else if ({1'b0, level_reg} <= decay_limit) begin
                                level_reg <= target;
                                state_reg <= ST_SUSTAIN;
                            end else begin
                                level_reg <= level_reg - DECAY_STEP;
                            end
                        end

                        ST_SUSTAIN: begin
                            if (!gate) begin
                                state_reg <= ST_RELEASE;
                            end else begin
                                // Tracks the sustain input continuously.
                                level_reg <= target;
                            end
                        end

                        ST_RELEASE: begin
                            if (level_reg <= RELEASE_STEP) begin
                                level_reg <= 16'd0;
                                state_reg <= ST_IDLE;
                            end else begin
                                level_reg <= level_reg - RELEASE_STEP;
                            end
                        end

                        default: begin
                            level_reg <= 16'd0;
                            state_reg <= ST_IDLE;
                        end
                    endcase
                end
            end else if (gate_rise) begin
                trig_pending_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling datapath. The level is treated as an unsigned fraction of
    // full scale (zero-extended to 17 bits before the signed multiply).
    // The upper half of the product gives a floor-rounded result. The
    // multiply uses the level from before this strobe's FSM update.
    // ------------------------------------------------------------------
    assign prod_next = 33'($signed(sig_in)) * 33'($signed({1'b0, level_reg}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q_reg    <= 1'b0;
            prod_reg      <= '0;
            sig_out_reg   <= 16'd0;
            out_valid_reg <= 1'b0;
        end else begin
            tick_q_reg    <= sample_tick;
            out_valid_reg <= tick_q_reg;
            if (sample_tick) begin
                prod_reg <= prod_next;
            end
            if (tick_q_reg) begin
                sig_out_reg <= prod_reg[31:16];
            end
        end
    end

    // Product bit 32 and the low half never reach the output.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_reg[32], prod_reg[15:0]};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sig_out   = sig_out_reg;
    assign out_valid = out_valid_reg;
    assign env_level = level_reg;
    assign env_state = state_reg;
    assign active    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// -----------------------------------------------------------------------------
// tb_envelope_adsr
//
// Self-checking bench for envelope_adsr. A behavioural model tracks the
// envelope with plain integers. Scaled results go into a queue of
// (due cycle, value) pairs. Each scenario task drives stimulus through
// advance() and compares the DUT against the model or against known
// constants.
// -----------------------------------------------------------------------------
module tb_envelope_adsr;

    localparam int ATTACK_STEP  = 64;
    localparam int DECAY_STEP   = 16;
    localparam int RELEASE_STEP = 8;

    localparam int ST_IDLE    = 0;
    localparam int ST_ATTACK  = 1;
    localparam int ST_DECAY   = 2;
    localparam int ST_SUSTAIN = 3;
    localparam int ST_RELEASE = 4;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        sample_tick = 1'b0;
    logic        gate        = 1'b0;
    logic [7:0]  sustain     = 8'h80;
    logic [15:0] sig_in      = 16'd0;
    logic [15:0] sig_out;
    logic        out_valid;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    envelope_adsr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .gate        (gate),
        .sustain     (sustain),
        .sig_in      (sig_in),
        .sig_out     (sig_out),
        .out_valid   (out_valid),
        .env_level   (env_level),
        .env_state   (env_state),
        .active      (active)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural model
    int m_state   = ST_IDLE;
    int m_level   = 0;
    int m_sig_out = 0;
    bit m_valid   = 1'b0;
    bit m_gate_q  = 1'b0;
    bit m_pend    = 1'b0;

    typedef struct {
        int due;
        int value;
    } result_t;
    result_t outq[$];

    function automatic int scaled(input logic [15:0] s, input int lvl);
        longint p;
        p = longint'($signed(s)) * longint'(lvl);
        return int'(p >>> 16);
    endfunction

    // One clock: apply the strobe and update the model. Outputs can be
    // read 1 time unit after the edge.
    task automatic advance(input bit tick);
        int target;
        bit rise;
        bit trig;
        sample_tick = tick;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_state   = ST_IDLE;
            m_level   = 0;
            m_sig_out = 0;
            m_valid   = 1'b0;
            m_gate_q  = 1'b0;
            m_pend    = 1'b0;
            outq.delete();
        end else begin
            m_valid = 1'b0;
            if (outq.size() != 0 && outq[0].due == cyc) begin
                m_valid   = 1'b1;
                m_sig_out = outq[0].value;
                outq.delete(0);
            end
            rise = gate && !m_gate_q;
            if (tick) begin
                outq.push_back('{due: cyc + 1, value: scaled(sig_in, m_level)});
                target = int'(sustain) * 257;
                trig   = m_pend || rise;
                m_pend = 1'b0;
                if (trig) begin
                    m_state = ST_ATTACK;
                end else begin
                    case (m_state)
                        ST_ATTACK: begin
                            if (!gate) m_state = ST_RELEASE;
                            else if (m_level + ATTACK_STEP >= 65535) begin
                                m_level = 65535;
                                m_state = ST_DECAY;
                            end else m_level = m_level + ATTACK_STEP;
                        end
                        ST_DECAY: begin
                            if (!gate) m_state = ST_RELEASE;
                            else if (m_level <= target + DECAY_STEP) begin
                                m_level = target;
                                m_state = ST_SUSTAIN;
                            end else m_level = m_level - DECAY_STEP;
                        end
                        ST_SUSTAIN: begin
                            if (!gate) m_state = ST_RELEASE;
                            else m_level = target;
                        end
                        ST_RELEASE: begin
                            if (m_level <= RELEASE_STEP) begin
                                m_level = 0;
                                m_state = ST_IDLE;
                            end else m_level = m_level - RELEASE_STEP;
                        end
                        default: begin
                            m_level = 0;
                            m_state = ST_IDLE;
                        end
                    endcase
                end
            end else if (rise) begin
                m_pend = 1'b1;
            end
            m_gate_q = gate;
        end
        #1;
        sample_tick = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        gate  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sig_in = 16'($urandom);
            advance(i[0]);
        end
        vectors += 5;
        if (env_state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d expected=0", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL reset_level got=%0d expected=0", env_level); end
        if (sig_out !== 16'd0) begin miscompares++; $display("FAIL reset_sig_out got=%0d expected=0", sig_out); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b expected=0", out_valid); end
        if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active got=%0b expected=0", active); end

        rst_n = 1'b1;
        advance(1'b0);
        advance(1'b0);
        sig_in = 16'($urandom);
        advance(1'b1);
        vectors += 4;
        if (env_state !== 3'd1) begin miscompares++; $display("FAIL first_tick_state got=%0d expected=1", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL first_tick_level got=%0d expected=0", env_level); end
        if (active !== 1'b1) begin miscompares++; $display("FAIL first_tick_active got=%0b expected=1", active); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL first_tick_early_valid got=%0b expected=0", out_valid); end
        advance(1'b0);
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first_tick_valid got=%0b expected=1", out_valid); end
        if (sig_out !== 16'd0) begin miscompares++; $display("FAIL first_tick_sig_out got=%0d expected=0", sig_out); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_attack_decay();
        int tick_no = 1;
        sustain = 8'h80;
        gate    = 1'b1;
        while (m_state != ST_SUSTAIN && tick_no < 4000) begin
            sig_in = 16'($urandom);
            advance(1'b1);
            tick_no++;
            vectors += 2;
            if (int'(env_state) !== m_state) begin miscompares++; $display("FAIL ad_state tick=%0d got=%0d expected=%0d", tick_no, env_state, m_state); end
            if (int'(env_level) !== m_level) begin miscompares++; $display("FAIL ad_level tick=%0d got=%0d expected=%0d", tick_no, env_level, m_level); end
            if (tick_no <= 1024) begin
                vectors++;
                if (int'(env_level) !== 64 * (tick_no - 1)) begin miscompares++; $display("FAIL attack_ramp tick=%0d got=%0d expected=%0d", tick_no, env_level, 64 * (tick_no - 1)); end
            end
            if (tick_no == 1025) begin
                vectors += 2;
                if (env_level !== 16'hFFFF) begin miscompares++; $display("FAIL attack_peak_level got=%0d expected=65535", env_level); end
                if (env_state !== 3'd2) begin miscompares++; $display("FAIL attack_peak_state got=%0d expected=2", env_state); end
            end
            if (tick_no > 1025) begin
                vectors++;
                if (env_level < 16'd32896) begin miscompares++; $display("FAIL decay_undershoot tick=%0d got=%0d expected>=32896", tick_no, env_level); end
            end
            for (int k = 0; k < 9; k++) begin
                advance(1'b0);
                if (k == 0) begin
                    vectors += 2;
                    if (out_valid !== m_valid) begin miscompares++; $display("FAIL ad_valid tick=%0d got=%0b expected=%0b", tick_no, out_valid, m_valid); end
                    if (int'($signed(sig_out)) !== m_sig_out) begin miscompares++; $display("FAIL ad_sig_out tick=%0d got=%0d expected=%0d", tick_no, $signed(sig_out), m_sig_out); end
                end
            end
        end
        vectors += 2;
        if (env_state !== 3'd3) begin miscompares++; $display("FAIL sustain_state got=%0d expected=3", env_state); end
        if (env_level !== 16'h8080) begin miscompares++; $display("FAIL sustain_level got=%0d expected=32896", env_level); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_release_retrigger();
        int prev = 32896;
        int guard = 0;
        gate = 1'b0;
        advance(1'b1);
        vectors += 2;
        if (env_state !== 3'd4) begin miscompares++; $display("FAIL release_entry_state got=%0d expected=4", env_state); end
        if (env_level !== 16'd32896) begin miscompares++; $display("FAIL release_entry_level got=%0d expected=32896", env_level); end
        while (m_level > 20000 && guard < 3000) begin
            sig_in = 16'($urandom);
            advance(1'b1);
            guard++;
            prev -= RELEASE_STEP;
            vectors += 2;
            if (int'(env_level) !== prev) begin miscompares++; $display("FAIL release_step n=%0d got=%0d expected=%0d", guard, env_level, prev); end
            if (env_state !== 3'd4) begin miscompares++; $display("FAIL release_state n=%0d got=%0d expected=4", guard, env_state); end
            repeat ($urandom_range(0, 2)) advance(1'b0);
        end
        gate = 1'b1;
        advance(1'b1);
        vectors += 2;
        if (env_state !== 3'd1) begin miscompares++; $display("FAIL retrigger_state got=%0d expected=1", env_state); end
        if (env_level !== 16'd20000) begin miscompares++; $display("FAIL retrigger_level got=%0d expected=20000", env_level); end
        advance(1'b1);
        vectors++;
        if (env_level !== 16'd20064) begin miscompares++; $display("FAIL retrigger_ramp got=%0d expected=20064", env_level); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back_multiply();
        int guard = 0;
        while (m_state != ST_DECAY && guard < 2000) begin
            sig_in = 16'($urandom);
            advance(1'b1);
            guard++;
            vectors += 3;
            if (int'(env_level) !== m_level) begin miscompares++; $display("FAIL b2b_level n=%0d got=%0d expected=%0d", guard, env_level, m_level); end
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid n=%0d got=%0b expected=1", guard, out_valid); end
            if (int'($signed(sig_out)) !== m_sig_out) begin miscompares++; $display("FAIL b2b_sig_out n=%0d got=%0d expected=%0d", guard, $signed(sig_out), m_sig_out); end
        end
        advance(1'b0);
        advance(1'b0);
        vectors += 2;
        if (env_state !== 3'd2) begin miscompares++; $display("FAIL mul_pre_state got=%0d expected=2", env_state); end
        if (env_level !== 16'hFFFF) begin miscompares++; $display("FAIL mul_pre_level got=%0d expected=65535", env_level); end

        gate   = 1'b0;
        sig_in = 16'h4000;
        advance(1'b1);
        vectors += 3;
        if (env_state !== 3'd4) begin miscompares++; $display("FAIL decay_release_state got=%0d expected=4", env_state); end
        if (env_level !== 16'hFFFF) begin miscompares++; $display("FAIL decay_release_level got=%0d expected=65535", env_level); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mul_pos_early got=%0b expected=0", out_valid); end
        advance(1'b0);
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mul_pos_valid got=%0b expected=1", out_valid); end
        if (sig_out !== 16'd16383) begin miscompares++; $display("FAIL mul_pos got=%0d expected=16383", $signed(sig_out)); end
        advance(1'b0);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mul_pos_pulse_len got=%0b expected=0", out_valid); end
        if (sig_out !== 16'd16383) begin miscompares++; $display("FAIL mul_hold got=%0d expected=16383", $signed(sig_out)); end

        sig_in = 16'hC000;
        advance(1'b1);
        advance(1'b0);
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mul_neg_valid got=%0b expected=1", out_valid); end
        if (sig_out !== 16'hC000) begin miscompares++; $display("FAIL mul_neg got=%0d expected=-16384", $signed(sig_out)); end

        guard = 0;
        while (m_state != ST_IDLE && guard < 10000) begin
            sig_in = 16'($urandom);
            advance(1'b1);
            guard++;
            vectors++;
            if (int'(env_level) !== m_level) begin miscompares++; $display("FAIL tail_level n=%0d got=%0d expected=%0d", guard, env_level, m_level); end
        end
        vectors += 3;
        if (env_state !== 3'd0) begin miscompares++; $display("FAIL tail_end_state got=%0d expected=0", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL tail_end_level got=%0d expected=0", env_level); end
        if (active !== 1'b0) begin miscompares++; $display("FAIL tail_end_active got=%0b expected=0", active); end
        sig_in = 16'h7FFF;
        advance(1'b1);
        advance(1'b1);
        advance(1'b0);
        vectors++;
        if (sig_out !== 16'd0) begin miscompares++; $display("FAIL idle_sig_out got=%0d expected=0", $signed(sig_out)); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_edge_between_ticks();
        gate = 1'b0;
        advance(1'b1);
        advance(1'b0);
        gate = 1'b1;
        repeat (3) advance(1'b0);
        gate = 1'b0;
        advance(1'b0);
        advance(1'b0);
        advance(1'b1);
        vectors += 2;
        if (env_state !== 3'd1) begin miscompares++; $display("FAIL pulse_attack got=%0d expected=1", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL pulse_level got=%0d expected=0", env_level); end
        advance(1'b0);
        advance(1'b1);
        vectors++;
        if (env_state !== 3'd4) begin miscompares++; $display("FAIL pulse_release got=%0d expected=4", env_state); end
        advance(1'b1);
        vectors++;
        if (env_state !== 3'd0) begin miscompares++; $display("FAIL pulse_idle got=%0d expected=0", env_state); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        int guard = 0;
        gate = 1'b1;
        while (m_state != ST_DECAY && guard < 1200) begin
            sig_in = 16'h7FFF;
            advance(1'b1);
            guard++;
        end
        vectors++;
        if (env_state !== 3'd2) begin miscompares++; $display("FAIL pre_reset_state got=%0d expected=2", env_state); end
        rst_n = 1'b0;
        advance(1'b0);
        rst_n = 1'b1;
        vectors += 5;
        if (env_state !== 3'd0) begin miscompares++; $display("FAIL midrst_state got=%0d expected=0", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL midrst_level got=%0d expected=0", env_level); end
        if (sig_out !== 16'd0) begin miscompares++; $display("FAIL midrst_sig_out got=%0d expected=0", $signed(sig_out)); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got=%0b expected=0", out_valid); end
        if (active !== 1'b0) begin miscompares++; $display("FAIL midrst_active got=%0b expected=0", active); end
        advance(1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_valid got=%0b expected=0", out_valid); end
        advance(1'b1);
        vectors += 2;
        if (env_state !== 3'd1) begin miscompares++; $display("FAIL post_rst_attack got=%0d expected=1", env_state); end
        if (env_level !== 16'd0) begin miscompares++; $display("FAIL post_rst_level got=%0d expected=0", env_level); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int n = 0; n < 6000; n++) begin
            sig_in = 16'($urandom);
            if ($urandom_range(0, 199) == 0) gate = ~gate;
            if ($urandom_range(0, 499) == 0) sustain = 8'($urandom);
            advance($urandom_range(0, 2) == 0);
            vectors += 5;
            if (int'(env_state) !== m_state) begin miscompares++; $display("FAIL rnd_state cyc=%0d got=%0d expected=%0d", cyc, env_state, m_state); end
            if (int'(env_level) !== m_level) begin miscompares++; $display("FAIL rnd_level cyc=%0d got=%0d expected=%0d", cyc, env_level, m_level); end
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid cyc=%0d got=%0b expected=%0b", cyc, out_valid, m_valid); end
            if (int'($signed(sig_out)) !== m_sig_out) begin miscompares++; $display("FAIL rnd_sig_out cyc=%0d got=%0d expected=%0d", cyc, $signed(sig_out), m_sig_out); end
            if (active !== (m_state != ST_IDLE)) begin miscompares++; $display("FAIL rnd_active cyc=%0d got=%0b expected=%0b", cyc, active, m_state != ST_IDLE); end
        end
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_release_retrigger();
        test_back_to_back_multiply();
        test_edge_between_ticks();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/envelope_adsr.md
Name: envelope_adsr

Overview:
- ADSR amplitude envelope stage directly downstream of sig_adder. It sits between the mixed oscillator signal and the sample consumers: the async RAM controller write path and pmod_out.
- Shapes the 16-bit signed mixed sample with a gate-driven attack/decay/sustain/release level, so notes fade in and out instead of hard-switching on play.
- All envelope timing advances once per audio sample strobe.

Parameters:
ATTACK_STEP, 16'd64, level increment per sample_tick in ATTACK
DECAY_STEP, 16'd16, level decrement per sample_tick in DECAY
RELEASE_STEP, 16'd8, level decrement per sample_tick in RELEASE

Ports:
clk  input  1  100MHz system clock
rst_n  input  1  synchronous active-low reset
sample_tick  input  1  one-clk pulse per audio sample (LRCLK-derived)
gate  input  1  debounced play button; high = note held
sustain  input  8  sustain level; target = {sustain, sustain}
sig_in  input  16  signed mixed sample from sig_adder
sig_out  output  16  signed enveloped sample
out_valid  output  1  one-clk pulse when sig_out updates
env_level  output  16  current unsigned envelope level
env_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
active  output  1  high when env_state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: env_state=IDLE, env_level=0, sig_out=0, out_valid=0, active=0, gate_q=0, trig_pending=0, product register=0.
  - Because gate_q resets to 0, a gate already held high when reset is released is treated as a rising edge.
- Reset asserted mid-note: everything returns to reset values on the next clk edge. No release tail is produced.
- Gate edge capture runs every clk:
  - gate_q <= gate.
  - trig_pending is set when gate & ~gate_q.
  - trig_pending is cleared on the cycle a sample_tick is consumed.
  - An edge coinciding with a tick is consumed by that tick.
- State and level update only on clk edges where sample_tick=1, in priority order:
  1. Trigger (trig_pending or new edge) from any state -> ATTACK. env_level is unchanged this tick (retrigger continues from the current level, no jump to 0).
  2. ATTACK: if gate=0 -> RELEASE, level unchanged. Else if level+ATTACK_STEP >= 65535 (17-bit sum) -> level=65535, DECAY. Else level += ATTACK_STEP.
  3. DECAY: if gate=0 -> RELEASE, level unchanged. Else if level <= target+DECAY_STEP (no-underflow compare) -> level=target, SUSTAIN. Else level -= DECAY_STEP.
  4. SUSTAIN: if gate=0 -> RELEASE, level unchanged. Else level=target; a sustain change takes effect on the next tick.
  5. RELEASE: if level <= RELEASE_STEP -> level=0, IDLE. Else level -= RELEASE_STEP.
  6. IDLE: level=0.
- No wrap-around: level never exceeds 65535 and never goes below 0.
- Datapath, 2-clk latency from sample_tick:
  - Tick cycle: P <= $signed(sig_in) * $signed({1'b0, env_level}), a 33-bit product using the level before this tick's update.
  - Next cycle: sig_out <= P[31:16] (arithmetic floor) and out_valid=1 for exactly one clk.
- out_valid never asserts without a preceding tick.
- Back-to-back ticks on consecutive clks are legal and produce consecutive out_valid pulses.
- sig_out holds between updates. In IDLE it outputs 0 after the next tick.
- active is combinational from env_state.

Test Plan:
- Reset: hold rst_n=0 with gate=1 and random sig_in -> all outputs 0. Release reset and give one tick -> env_state=ATTACK, env_level=0.
- Attack/decay with ATTACK_STEP=64, DECAY_STEP=16, sustain=8'h80 (target 16'h8080), gate held, tick every 10 clks:
  - level climbs in steps of 64.
  - Tick 1025 -> level=65535, DECAY.
  - Level then falls in steps of 16 and clamps to 32896 in SUSTAIN; it never undershoots.
- Multiply: level=65535 and sig_in=16'h4000 -> sig_out=16383. sig_in=16'hC000 -> sig_out=-16384 (16'hC000). In both cases out_valid pulses exactly 2 clks after the tick.
- Release/retrigger:
  - Drop gate in SUSTAIN -> RELEASE next tick, level unchanged, then decreasing by 8 per tick.
  - Re-raise gate at level 20000 -> ATTACK from 20000.
  - Let the release complete -> level=0, IDLE, active=0.
- Edge between ticks: gate pulses high for 3 clks entirely between two ticks -> next tick enters ATTACK; the following tick enters RELEASE.
- Mid-note reset: pulse rst_n low for 1 clk while in DECAY -> IDLE, level 0, sig_out 0 on the next clk.
